// File: rtl/zxuno_regbus_ctrl.sv
// ZX-UNO extended register bus front end: decodes the address/data I/O ports,
// holds the current register address, strobes peripherals and muxes read data.
module zxuno_regbus_ctrl #(
   parameter int unsigned NPERIPH   = 4,
   parameter logic [15:0] ADDR_PORT = 16'hFC3B,
   parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          a,
   input  logic                 iorq_n,
   input  logic                 rd_n,
   input  logic                 wr_n,
   input  logic [7:0]           din,
   input  logic [8*NPERIPH-1:0] periph_dout,
   input  logic [NPERIPH-1:0]   periph_oe_n,
   output logic [7:0]           zxuno_addr,
   output logic                 zxuno_regrd,
   output logic                 zxuno_regwr,
   output logic                 regaddr_changed,
   output logic [7:0]           dout,
   output logic                 oe_n
);

   typedef enum logic [1:0] {StIdle, StRdData, StRdAddr, StWaitEnd} state_t;

   state_t     state;
   logic       acc, wr, rd;
   logic       hit_addr, hit_data;
   logic [7:0] periph_sel;
   logic       periph_found;

   assign wr       = !iorq_n && !wr_n;
   assign rd       = !iorq_n && !rd_n;
   assign acc      = wr || rd;
   assign hit_addr = (a == ADDR_PORT);
   assign hit_data = (a == DATA_PORT);

   // Reset parks in StWaitEnd so an access still on the bus at release is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= StWaitEnd;
         zxuno_addr      <= 8'h00;
         regaddr_changed <= 1'b0;
         zxuno_regwr     <= 1'b0;
         zxuno_regrd     <= 1'b0;
      end else begin
         regaddr_changed <= 1'b0;
         zxuno_regwr     <= 1'b0;
         unique case (state)
            StIdle: begin
               if (wr && hit_addr) begin
                  zxuno_addr      <= din;
                  regaddr_changed <= 1'b1;
                  state           <= StWaitEnd;
               end else if (wr && hit_data) begin
                  zxuno_regwr <= 1'b1;
                  state       <= StWaitEnd;
               end else if (rd && hit_data) begin
                  zxuno_regrd <= 1'b1;
                  state       <= StRdData;
               end else if (rd && hit_addr) begin
                  state <= StRdAddr;
               end
            end
            StRdData: begin
               if (!rd) begin
                  zxuno_regrd <= 1'b0;
                  state       <= StIdle;
               end
            end
            StRdAddr: begin
               if (!rd) state <= StIdle;
            end
            StWaitEnd: begin
               if (!acc) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Lowest-index enabled peripheral wins.
   always_comb begin
      periph_sel   = 8'hFF;
      periph_found = 1'b0;
      for (int unsigned k = 0; k < NPERIPH; k++) begin
         if (!periph_found && !periph_oe_n[k]) begin
            periph_sel   = periph_dout[8*k +: 8];
            periph_found = 1'b1;
         end
      end
   end

   always_comb begin
      oe_n = 1'b1;
      dout = 8'hFF;
      if (state == StRdData && zxuno_regrd) begin
         oe_n = 1'b0;
         dout = periph_sel;
      end else if (state == StRdAddr) begin
         oe_n = 1'b0;
         dout = zxuno_addr;
      end
   end

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// Bench for zxuno_regbus_ctrl: directed bus accesses plus a random access mix,
// checked against a cycle-level access model of the register bus.
module tb_zxuno_regbus_ctrl;

   localparam int unsigned NP = 4;
   localparam logic [15:0] AP = 16'hFC3B;
   localparam logic [15:0] DP = 16'hFD3B;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   a;
   logic          iorq_n, rd_n, wr_n;
   logic [7:0]    din;
   logic [8*NP-1:0] periph_dout;
   logic [NP-1:0] periph_oe_n;
   logic [7:0]    zxuno_addr, dout;
   logic          zxuno_regrd, zxuno_regwr, regaddr_changed, oe_n;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] m_addr;

   zxuno_regbus_ctrl #(.NPERIPH(NP), .ADDR_PORT(AP), .DATA_PORT(DP)) dut (
      .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .din(din), .periph_dout(periph_dout), .periph_oe_n(periph_oe_n),
      .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
      .regaddr_changed(regaddr_changed), .dout(dout), .oe_n(oe_n)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] arb_model(input logic [8*NP-1:0] d, input logic [NP-1:0] en_n);
      logic [7:0] bytes[NP];
      for (int i = 0; i < NP; i++) bytes[i] = d[8*i +: 8];
      for (int i = 0; i < NP; i++) if (en_n[i] == 1'b0) return bytes[i];
      return 8'hFF;
   endfunction

   task automatic bus_idle();
      iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      a = 16'($urandom);
   endtask

   // OUT (port),data held for hold clocks; din scrambled after the first sample.
   task automatic out_access(input logic [15:0] port, input logic [7:0] data, input int hold);
      a = port; din = data; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         if (i == 0 && port == AP) m_addr = data;
         chk("out_regaddr_changed", 16'(regaddr_changed), 16'(i == 0 && port == AP));
         chk("out_regwr", 16'(zxuno_regwr), 16'(i == 0 && port == DP));
         chk("out_addr", 16'(zxuno_addr), 16'(m_addr));
         chk("out_regrd", 16'(zxuno_regrd), 16'h0);
         chk("out_oe_n", 16'(oe_n), 16'h1);
         din = 8'($urandom);
      end
      bus_idle();
      step();
      chk("out_end_strobes", {14'h0, regaddr_changed, zxuno_regwr}, 16'h0);
      chk("out_end_addr", 16'(zxuno_addr), 16'(m_addr));
   endtask

   // IN (port) held for hold clocks; peripherals keep the current setup.
   task automatic in_access(input logic [15:0] port, input int hold);
      logic is_d, is_a;
      is_d = (port == DP);
      is_a = (port == AP);
      a = port; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
      #1;
      chk("in_decode_oe_n", 16'(oe_n), 16'h1);
      chk("in_decode_dout", 16'(dout), 16'hFF);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("in_regrd", 16'(zxuno_regrd), 16'(is_d));
         chk("in_oe_n", 16'(oe_n), 16'(!(is_d || is_a)));
         chk("in_dout", 16'(dout),
             16'(is_d ? arb_model(periph_dout, periph_oe_n) : (is_a ? m_addr : 8'hFF)));
         chk("in_strobes", {14'h0, regaddr_changed, zxuno_regwr}, 16'h0);
      end
      bus_idle();
      #1;
      chk("in_release_regrd", 16'(zxuno_regrd), 16'(is_d));
      step();
      chk("in_after_regrd", 16'(zxuno_regrd), 16'h0);
      chk("in_after_oe_n", 16'(oe_n), 16'h1);
      chk("in_after_addr", 16'(zxuno_addr), 16'(m_addr));
   endtask

   initial begin
      logic [15:0] ports[5];
      rst = 1'b1; din = 8'h00; m_addr = 8'h00;
      periph_dout = '1; periph_oe_n = '1;
      bus_idle();
      #1;
      chk("rst_addr", 16'(zxuno_addr), 16'h00);
      chk("rst_strobes", {13'h0, zxuno_regrd, zxuno_regwr, regaddr_changed}, 16'h0);
      chk("rst_oe_n", 16'(oe_n), 16'h1);
      step(); step();
      rst = 1'b0;
      step();

      // Address write, then peripheral 0 read twice
      out_access(AP, 8'hFF, 4);
      periph_dout = {8'h33, 8'h22, 8'h11, 8'h54};
      periph_oe_n = 4'b1110;
      in_access(DP, 5);
      in_access(DP, 5);

      // Arbitration priority and no-enable case
      periph_oe_n = 4'b1001;
      in_access(DP, 3);
      periph_oe_n = 4'b1111;
      in_access(DP, 2);

      // Address read-back and data write
      out_access(AP, 8'h3A, 2);
      in_access(AP, 3);
      out_access(DP, 8'h5C, 6);

      // Reset in the middle of a data-port read, released while still active
      periph_oe_n = 4'b1110;
      a = DP; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
      step(); step();
      chk("pre_rst_regrd", 16'(zxuno_regrd), 16'h1);
      rst = 1'b1;
      #1;
      m_addr = 8'h00;
      chk("async_rst_regrd", 16'(zxuno_regrd), 16'h0);
      chk("async_rst_addr", 16'(zxuno_addr), 16'h00);
      chk("async_rst_oe_n", 16'(oe_n), 16'h1);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_regrd", 16'(zxuno_regrd), 16'h0);
         chk("post_rst_oe_n", 16'(oe_n), 16'h1);
      end
      bus_idle();
      step();
      in_access(DP, 2);

      // Near-miss addresses decode nothing
      out_access(16'hFC3A, 8'h77, 3);
      in_access(16'hFD3C, 3);

      // Back-to-back write then read with no idle gap: single access, no regrd
      a = AP; din = 8'h21; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
      step();
      m_addr = 8'h21;
      chk("b2b_changed", 16'(regaddr_changed), 16'h1);
      a = DP; wr_n = 1'b1; rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("b2b_regrd", 16'(zxuno_regrd), 16'h0);
         chk("b2b_oe_n", 16'(oe_n), 16'h1);
      end
      bus_idle();
      step();

      // Random access mix
      ports[0] = AP; ports[1] = DP; ports[2] = AP ^ 16'h0001;
      ports[3] = DP + 16'h0001;
      for (int n = 0; n < 60; n++) begin
         ports[4] = 16'($urandom);
         periph_dout = 32'($urandom);
         periph_oe_n = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            out_access(ports[$urandom_range(0, 4)], 8'($urandom), $urandom_range(1, 5));
         else
            in_access(ports[$urandom_range(0, 4)], $urandom_range(1, 5));
         if ($urandom_range(0, 3) == 0) begin
            bus_idle();
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/zxuno_regbus_ctrl.md
Name: zxuno_regbus_ctrl

Overview:
- Front-end controller for the ZX-UNO extended register bus.
- Decodes Z80 I/O accesses to the register-address port and the register-data port.
- Holds the current register address and sequences per-access strobes to the register peripherals (core ID text, config registers, etc.).
- Arbitrates their read data back onto the CPU data bus.

Parameters:
- NPERIPH, 4: number of register peripherals on the read-back arbiter.
- ADDR_PORT, 16'hFC3B: I/O address of the register-address port.
- DATA_PORT, 16'hFD3B: I/O address of the register-data port.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  16  Z80 address bus (already synchronous to clk).
- iorq_n  in  1  Z80 IORQ, active low.
- rd_n  in  1  Z80 RD, active low.
- wr_n  in  1  Z80 WR, active low.
- din  in  8  CPU write data.
- periph_dout  in  8*NPERIPH  peripheral read data; peripheral k on bits [8k+7:8k].
- periph_oe_n  in  NPERIPH  peripheral output enables, active low.
- zxuno_addr  out  8  current register address.
- zxuno_regrd  out  1  level: data-port read in progress.
- zxuno_regwr  out  1  one-cycle pulse per data-port write.
- regaddr_changed  out  1  one-cycle pulse after the address port is written.
- dout  out  8  read data to the CPU bus mux.
- oe_n  out  1  active low; this block drives dout.

Behaviour:
- States: IDLE, RD_DATA, RD_ADDR, WAIT_END.
- Access qualifiers, evaluated on registered state:
  - acc = !iorq_n && (!rd_n || !wr_n).
  - wr = !iorq_n && !wr_n.
  - rd = !iorq_n && !rd_n.
- IDLE, transitions (first matching case wins):
  - wr && a==ADDR_PORT: next edge loads zxuno_addr<=din, regaddr_changed<=1, state WAIT_END.
  - wr && a==DATA_PORT: next edge sets zxuno_regwr<=1, state WAIT_END.
  - rd && a==DATA_PORT: next edge sets zxuno_regrd<=1, state RD_DATA.
  - rd && a==ADDR_PORT: state RD_ADDR.
  - Any other access, or no access: stay in IDLE.
- regaddr_changed and zxuno_regwr are registered and cleared on the following edge. Each is exactly one clk wide per CPU access, however long the access lasts.
- zxuno_addr is captured only from the first sampled cycle of the write. Later din changes within the same access are ignored.
- RD_DATA:
  - zxuno_regrd stays 1 while rd is true.
  - On the first edge where rd is false: zxuno_regrd<=0, state IDLE. regrd falls exactly 1 clk after the bus releases.
- RD_ADDR: return to IDLE on the first edge where rd is false.
- WAIT_END: return to IDLE on the first edge where acc is false. Each access produces at most one action.
- oe_n:
  - Combinational: 0 iff (state==RD_DATA && zxuno_regrd) or state==RD_ADDR; else 1.
  - 1 in IDLE, including the first decode cycle of a read. Latency from read start to oe_n=0 is 1 clk.
- dout:
  - RD_ADDR: zxuno_addr.
  - RD_DATA: periph_dout of the lowest-index k with periph_oe_n[k]==0; 8'hFF if none is enabled.
  - oe_n=1: 8'hFF.
- Address-port read-back never touches zxuno_regrd or any peripheral.
- Only a full 16-bit address match decodes; any other address is ignored.
- Reset (asynchronous, any time):
  - zxuno_addr=8'h00; regaddr_changed=0; zxuno_regwr=0; zxuno_regrd=0.
  - state=WAIT_END, so an access still active at reset release generates no strobe or address load.
  - With the bus idle, the state reaches IDLE 1 clk after release.
- Back-to-back accesses need at least one clk of acc false between them to be recognised as separate accesses; otherwise the controller treats them as a single access.

Test Plan:
- Reset, then OUT (FC3B),8'hFF held 4 clk -> zxuno_addr=FF one clk after decode; regaddr_changed high exactly 1 clk; zxuno_regwr=0.
- Address FF selected; peripheral 0 asserts oe_n with data 'T' during IN (FD3B) held 5 clk -> regrd high 1 clk after decode through 1 clk past release; oe_n=0 and dout=8'h54 while regrd is high; repeat the IN -> regrd pulses again.
- periph_oe_n=4'b1001, periph_dout 1->8'h11, 3->8'h33, IN (FD3B) -> dout=8'h11; with periph_oe_n=4'b1111 -> dout=8'hFF, oe_n=0.
- OUT (FC3B),8'h3A then IN (FC3B) -> dout=8'h3A, oe_n=0, zxuno_regrd stays 0; OUT (FD3B) held 6 clk -> zxuno_regwr exactly 1 clk.
- Assert rst mid IN (FD3B), release while the read is still active -> regrd=0 immediately, zxuno_addr=00, no regrd until after one idle clk and a new access.
- OUT to 16'hFC3A and IN from 16'hFD3C -> no strobes, oe_n stays 1, zxuno_addr unchanged.
